mixer_tdm: RTL and testbench

MIXER_TDM -- requirements
Module: mixer_tdm

---
 rtl/synth_pkg.sv | 19 +
 rtl/mixer_tdm_mac.sv | 52 +++++
 rtl/mixer_tdm.sv | 178 +++++++++++++++++
 tb/tb_mixer_tdm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and FSM state encoding for the TDM voice mixer.
package synth_pkg;

  localparam int unsigned BitdepthDefault = 14;

  // Offset-binary silence level for a given sample width.
  function automatic int unsigned midscale_of(input int unsigned bd);
    return 32'd1 << (bd - 1);
  endfunction

  localparam int unsigned MidscaleDefault = midscale_of(BitdepthDefault);

  // Mixer FSM state encoding
  typedef logic [1:0] mix_state_t;
  localparam mix_state_t StIdle  = 2'd0;
  localparam mix_state_t StAccum = 2'd1;
  localparam mix_state_t StOut   = 2'd2;

endpackage

// File: rtl/mixer_tdm_mac.sv
// Signed multiply-accumulate for one mixer channel per cycle.
// acc_sum_o is the running total including the current channel's product.
module mixer_tdm_mac #(
  parameter int unsigned BITDEPTH = 14,
  parameter int unsigned GAINW    = 4,
  parameter int unsigned AccW     = 22
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic [BITDEPTH-1:0]        sample_i,
  input  logic [GAINW-1:0]           gain_i,
  input  logic                       muted_i,
  output logic signed [AccW-1:0]     acc_sum_o
);

  localparam int unsigned ProdW = BITDEPTH + GAINW + 1;

  logic signed [BITDEPTH-1:0] sample_s;
  logic signed [GAINW:0]      gain_s;
  logic signed [ProdW-1:0]    prod;
  logic signed [AccW-1:0]     acc_q, acc_d;

  // Offset-binary to two's complement; gain is unsigned so zero-extend it.
  always_comb begin
    sample_s  = {~sample_i[BITDEPTH-1], sample_i[BITDEPTH-2:0]};
    gain_s    = {1'b0, gain_i};
    prod      = muted_i ? '0 : ProdW'(sample_s) * ProdW'(gain_s);
    acc_sum_o = acc_q + AccW'(prod);
  end

  // Accumulator next state: clear on frame start, add while enabled
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_sum_o;
    end
  end

  // Accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mixer_tdm.sv
// Time-division multiplexed voice mixer: one channel MAC per cycle, result
// registered on the last channel so mix_valid lands NCH+1 cycles after tick.
// Optional feature: define MIXER_TDM_SATURATE_EN to clamp instead of wrap.
module mixer_tdm
  import synth_pkg::*;
#(
  parameter int unsigned NCH      = 8,
  parameter int unsigned BITDEPTH = BitdepthDefault,
  parameter int unsigned GAINW    = 4,
  parameter int unsigned HEADROOM = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [NCH*BITDEPTH-1:0]   in_flat,
  input  logic [NCH*GAINW-1:0]      gain_flat,
  input  logic [NCH-1:0]            mute,
  output logic [BITDEPTH-1:0]       mix,
  output logic                      mix_valid,
  output logic                      busy,
  output logic                      clip,
  output logic                      overrun
);

  localparam int unsigned IdxW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AccW  = BITDEPTH + GAINW + $clog2(NCH) + 1;
  localparam int unsigned Shift = GAINW - 1 + HEADROOM;
  localparam logic [BITDEPTH-1:0] MidScale = BITDEPTH'(midscale_of(BITDEPTH));
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NCH - 1);

  mix_state_t                state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [NCH*BITDEPTH-1:0]   in_q, in_d;
  logic [NCH*GAINW-1:0]      gain_q, gain_d;
  logic [NCH-1:0]            mute_q, mute_d;
  logic [BITDEPTH-1:0]       mix_q, mix_d;
  logic                      mix_valid_q, mix_valid_d;
  logic                      clip_q, clip_d;
  logic                      overrun_q, overrun_d;

  logic                      acc_clear, acc_en;
  logic [BITDEPTH-1:0]       cur_sample;
  logic [GAINW-1:0]          cur_gain;
  logic                      cur_mute;
  logic signed [AccW-1:0]    acc_sum;
  logic signed [AccW-1:0]    shifted;
  logic [BITDEPTH-1:0]       res;
  logic                      clip_res;
  logic [BITDEPTH-1:0]       out_word;

  // Select the snapshotted channel addressed by idx
  always_comb begin
    cur_sample = '0;
    cur_gain   = '0;
    cur_mute   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_sample = in_q[i*BITDEPTH +: BITDEPTH];
        cur_gain   = gain_q[i*GAINW +: GAINW];
        cur_mute   = mute_q[i];
      end
    end
  end

  mixer_tdm_mac #(
    .BITDEPTH (BITDEPTH),
    .GAINW    (GAINW),
    .AccW     (AccW)
  ) u_mac (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (acc_clear),
    .en_i      (acc_en),
    .sample_i  (cur_sample),
    .gain_i    (cur_gain),
    .muted_i   (cur_mute),
    .acc_sum_o (acc_sum)
  );

  // Output stage: scale the final sum, then clamp or wrap to sample width
  always_comb begin
    shifted  = acc_sum >>> Shift;
    res      = BITDEPTH'(shifted);
    clip_res = 1'b0;
`ifdef MIXER_TDM_SATURATE_EN
    if (shifted > $signed(AccW'((1 << (BITDEPTH - 1)) - 1))) begin
      res      = {1'b0, {(BITDEPTH-1){1'b1}}};
      clip_res = 1'b1;
    end else if (shifted < -$signed(AccW'(1 << (BITDEPTH - 1)))) begin
      res      = {1'b1, {(BITDEPTH-1){1'b0}}};
      clip_res = 1'b1;
    end
`endif
    out_word = {~res[BITDEPTH-1], res[BITDEPTH-2:0]};
  end

  // FSM next state, snapshot capture and output register updates
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_d        = in_q;
    gain_d      = gain_q;
    mute_d      = mute_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    clip_d      = clip_q;
    overrun_d   = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_tick) begin
          in_d      = in_flat;
          gain_d    = gain_flat;
          mute_d    = mute;
          idx_d     = '0;
          acc_clear = 1'b1;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        acc_en    = 1'b1;
        overrun_d = sample_tick;
        if (idx_q == LastIdx) begin
          // Register the result now so it is visible during OUT
          mix_d       = out_word;
          clip_d      = clip_res;
          mix_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        // A tick here is still an overrun; the frame is not yet released
        overrun_d = sample_tick;
        idx_d     = '0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      in_q        <= '0;
      gain_q      <= '0;
      mute_q      <= '0;
      mix_q       <= MidScale;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_q        <= in_d;
      gain_q      <= gain_d;
      mute_q      <= mute_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mix       = mix_q;
  assign mix_valid = mix_valid_q;
  assign busy      = (state_q != StIdle);
  assign clip      = clip_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_tdm.sv
// Directed self-checking bench for mixer_tdm (NCH=8, BITDEPTH=14, GAINW=4, HEADROOM=2).
module tb_mixer_tdm;

  localparam int NCH = 8;
  localparam int BD  = 14;
  localparam int GW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample_tick = 1'b0;
  logic [NCH*BD-1:0] in_flat = '0;
  logic [NCH*GW-1:0] gain_flat = '0;
  logic [NCH-1:0]    mute = '0;
  logic [BD-1:0]     mix;
  logic              mix_valid, busy, clip, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  mixer_tdm #(
    .NCH      (NCH),
    .BITDEPTH (BD),
    .GAINW    (GW),
    .HEADROOM (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .in_flat     (in_flat),
    .gain_flat   (gain_flat),
    .mute        (mute),
    .mix         (mix),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .clip        (clip),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [BD-1:0] s, input logic [GW-1:0] g, input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++) begin
      in_flat[i*BD +: BD]   = s;
      gain_flat[i*GW +: GW] = g;
    end
    mute = m;
  endtask

  // Tick once, then watch 20 cycles sampling at negedges (n = cycles after tick).
  // Optional second tick at cycle tick2_at and input change at cycle change_at.
  task automatic do_frame(input int tick2_at, input int change_at,
                          input logic [NCH*BD-1:0] alt_in, input logic [NCH-1:0] alt_mute,
                          output int lat, output int nvalid, output int novr, output int ovr_at,
                          output logic [20:0] busy_v);
    lat = -1; nvalid = 0; novr = 0; ovr_at = -1; busy_v = '0;
    @(negedge clk);
    busy_v[0] = busy;
    sample_tick = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 20; n++) begin
      busy_v[n] = busy;
      if (mix_valid) begin
        nvalid++;
        if (lat < 0) lat = n;
      end
      if (overrun) begin
        novr++;
        ovr_at = n;
      end
      sample_tick = (n == tick2_at);
      if (n == change_at) begin
        in_flat = alt_in;
        mute    = alt_mute;
      end
      @(negedge clk);
    end
    sample_tick = 1'b0;
  endtask

  // Plain frame: checks latency, single pulse, busy window, no overrun, result.
  task automatic run_plain(input string tag, input logic [BD-1:0] exp_mix, input logic exp_clip);
    int lat, nv, no, oa;
    logic [20:0] bv;
    do_frame(0, 0, '0, '0, lat, nv, no, oa, bv);
    check_eq({tag, "_lat"}, lat, 9);
    check_eq({tag, "_nvalid"}, nv, 1);
    check_eq({tag, "_novr"}, no, 0);
    check_eq({tag, "_busy"}, {bv[0], bv[1], bv[9], bv[10]}, 4'b0110);
    check_eq({tag, "_mix"}, mix, exp_mix);
    check_eq({tag, "_clip"}, clip, exp_clip);
  endtask

  initial begin
    int lat, nv, no, oa, cnt;
    logic [20:0] bv;
    logic [NCH*BD-1:0] alt;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_mix", mix, 14'h2000);
    check_eq("rst_flags", {mix_valid, busy, clip, overrun}, 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    // Silence in, silence out
    set_all(14'h2000, 4'hF, 8'h00);
    run_plain("silence", 14'h2000, 1'b0);

    // Single channel unity gain
    set_all(14'h2000, 4'h8, 8'hFE);
    in_flat[0 +: BD] = 14'h3000;
    run_plain("ch0_pos", 14'h2400, 1'b0);

    // Negative single channel
    in_flat[0 +: BD] = 14'h1000;
    run_plain("ch0_neg", 14'h1C00, 1'b0);

    // Three channels with different gains: 32768 - 16384 + 30720 = 47104 >> 5 = 1472
    set_all(14'h2000, 4'h0, 8'hF8);
    in_flat[0*BD +: BD] = 14'h3000; gain_flat[0*GW +: GW] = 4'd8;
    in_flat[1*BD +: BD] = 14'h1000; gain_flat[1*GW +: GW] = 4'd4;
    in_flat[2*BD +: BD] = 14'h2800; gain_flat[2*GW +: GW] = 4'd15;
    run_plain("three_ch", 14'h25C0, 1'b0);

    // Mute removes ch2 contribution: 16384 >> 5 = 512
    mute = 8'hFC;
    run_plain("mute_ch2", 14'h2200, 1'b0);

    // Full-scale positive / negative overload
    set_all(14'h3FFF, 4'hF, 8'h00);
`ifdef MIXER_TDM_SATURATE_EN
    run_plain("ovl_pos", 14'h3FFF, 1'b1);
    set_all(14'h0000, 4'hF, 8'h00);
    run_plain("ovl_neg", 14'h0000, 1'b1);
`else
    run_plain("ovl_pos", 14'h17FC, 1'b0);
    set_all(14'h0000, 4'hF, 8'h00);
    run_plain("ovl_neg", 14'h2800, 1'b0);
`endif
    // Clean frame after overload clears clip
    set_all(14'h2000, 4'h8, 8'hFE);
    in_flat[0 +: BD] = 14'h3000;
    run_plain("post_ovl", 14'h2400, 1'b0);

    // Second tick 3 cycles in: overrun pulse one cycle later, frame unchanged
    do_frame(3, 0, '0, '0, lat, nv, no, oa, bv);
    check_eq("ovr_count", no, 1);
    check_eq("ovr_at", oa, 4);
    check_eq("ovr_nvalid", nv, 1);
    check_eq("ovr_lat", lat, 9);
    check_eq("ovr_mix", mix, 14'h2400);

    // Tick during OUT is an overrun and does not start a new frame
    do_frame(9, 0, '0, '0, lat, nv, no, oa, bv);
    check_eq("out_tick_ovr_at", oa, 10);
    check_eq("out_tick_nvalid", nv, 1);
    check_eq("out_tick_busy11", bv[11], 1'b0);

    // Inputs change during ACCUM: snapshot must be used
    for (int i = 0; i < NCH; i++) alt[i*BD +: BD] = 14'h3FFF;
    do_frame(0, 2, alt, 8'h00, lat, nv, no, oa, bv);
    check_eq("snap_mix", mix, 14'h2400);
    check_eq("snap_nvalid", nv, 1);

    // Reset mid-frame aborts without a mix_valid pulse
    set_all(14'h2000, 4'h8, 8'hFE);
    in_flat[0 +: BD] = 14'h1000;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_mix", mix, 14'h2000);
    check_eq("abort_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (mix_valid) cnt++;
    end
    check_eq("abort_nvalid", cnt, 0);
    run_plain("after_abort", 14'h1C00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
